axi_lite_reg_slave: RTL and testbench
=====================================

AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, AXI data width in bits; each register is this width.
REQ-003 Parameter NUM_REGS, default 8, number of RW registers; power of two, 2..256.
REQ-004 ACLK  input  1  single clock; all state updates on rising edge.
REQ-005 ARESETN  input  1  asynchronous active-low reset; deassertion synchronous to ACLK externally.
REQ-006 AWADDR/AWVALID  input  ADDR_WIDTH/1  write address channel; AWREADY  output  1.
REQ-007 WDATA/WVALID  input  DATA_WIDTH/1  write data channel; WREADY  output  1.
REQ-008 BRESP  output  2  and BVALID  output  1  write response; BREADY  input  1.
REQ-009 ARADDR/ARVALID  input  ADDR_WIDTH/1  read address channel; ARREADY  output  1.
REQ-010 RDATA  output  DATA_WIDTH, RRESP  output  2, RVALID  output  1  read data channel; RREADY  input  1.
REQ-011 reg_q  output  NUM_REGS*DATA_WIDTH  live register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-012 Decode: word address; index = ADDR[log2(NUM_REGS)+1:2]; ADDR[1:0] ignored; ADDR >= NUM_REGS*4 is out of range.
REQ-013 AW and W accepted independently, either order or same cycle; each held in a one-entry latch.
REQ-014 AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
REQ-015 Commit occurs on the edge where both latches are full (or filling that edge) and BVALID is 0: in-range -> register written with WDATA, BRESP=2'b00 (OKAY); out-of-range -> no register change, BRESP=2'b10 (SLVERR).
REQ-016 At commit edge: BVALID rises, both latches clear; minimum latency AW&W handshake at edge N -> BVALID high after edge N+1 is not allowed; BVALID high after edge N (same edge as the write).
REQ-017 BVALID, BRESP held stable until BVALID&&BREADY edge; BVALID clears there; AWREADY/WREADY return high the following cycle.
REQ-018 ARREADY = !RVALID.
REQ-019 On ARVALID&&ARREADY edge: RVALID rises, RDATA = addressed register (in-range, RRESP=2'b00) or 0 (out-of-range, RRESP=2'b10).
REQ-020 RDATA, RRESP held stable while RVALID&&!RREADY; RVALID clears on RVALID&&RREADY edge.
REQ-021 Read and write paths fully independent; concurrent operations never stall each other.
REQ-022 Read handshake on same edge as write commit to same register returns pre-write value.
REQ-023 VALID outputs never depend combinationally on READY inputs; no output changes while its VALID is high and not yet accepted.
REQ-024 Second AW while aw_held (W missing) is not accepted; AWREADY stays low until commit and B handshake complete; same for W.

Reset
REQ-025 ARESETN low asynchronously clears: all registers, latches, BVALID, RVALID, BRESP, RRESP, RDATA to 0.
REQ-026 During reset AWREADY, WREADY, ARREADY driven 0; they go high first full cycle after ARESETN deasserts.
REQ-027 Reset mid-transaction discards held AW/W, pending B and R; no partial register write.

Verification
REQ-028 AW 0x04 and W 0xDEADBEEF same cycle, BREADY=1 -> BVALID next cycle, BRESP=00, reg_q[1]=0xDEADBEEF; read 0x04 -> RDATA 0xDEADBEEF, RRESP=00.
REQ-029 W 0x12345678 three cycles before AW 0x08 -> WREADY low after W accept, commit at AW edge, reg 2 = 0x12345678, BRESP=00.
REQ-030 Write 0x40 (NUM_REGS=8) data 0xFFFFFFFF -> BRESP=10, all reg_q unchanged; read 0x40 -> RDATA=0, RRESP=10.
REQ-031 BREADY held low 5 cycles after commit -> BVALID/BRESP stable, AWREADY/WREADY low throughout, new AW not accepted until after B handshake.
REQ-032 reg 3 = 0xA5A5A5A5; read 0x0C handshake on same edge as commit of 0x5A5A5A5A to 0x0C -> RDATA 0xA5A5A5A5, next read 0x5A5A5A5A.
REQ-033 ARESETN pulsed low with AW held and RVALID pending RREADY=0 -> all VALIDs 0 immediately, reg_q all 0, no commit after release.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI4-Lite slave that exposes NUM_REGS read/write registers of DATA_WIDTH
// bits each, on word addresses 0, 4, 8, ... Accesses at or above NUM_REGS*4
// complete with SLVERR and do not touch any register.
//
// The write address and write data channels are each captured in a one-entry
// holding latch, so AW and W may arrive in either order or together. The
// write commits on the edge where both are available. The read path is
// independent of the write path and has a single response in flight.
//
// Ports
//   ACLK, ARESETN                  clock, asynchronous active-low reset
//   AWADDR, AWVALID, AWREADY       write address channel
//   WDATA, WVALID, WREADY          write data channel
//   BRESP, BVALID, BREADY          write response channel
//   ARADDR, ARVALID, ARREADY       read address channel
//   RDATA, RRESP, RVALID, RREADY   read data channel
//   reg_q                          live register contents; register i sits at
//                                  bits [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // An address is in range when every bit above the register index is zero.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (IDX_W + 2)) == '0;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  ready_en;   // low during reset and for the first edge after it
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Handshake and commit decode
  // ---------------------------------------------------------------------------
  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ok;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;

  assign AWREADY = ready_en && !aw_held && !BVALID;
  assign WREADY  = ready_en && !w_held  && !BVALID;
  assign ARREADY = ready_en && !RVALID;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID  && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  // A channel arriving this edge is used directly, so the commit does not
  // wait an extra cycle for the latch to fill.
  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_data = w_held  ? w_data_q  : WDATA;
  assign commit  = (aw_held || aw_fire) && (w_held || w_fire) && !BVALID;
  assign wr_ok   = in_range(wr_addr);
  assign wr_idx  = wr_addr[IDX_W+1:2];
  assign rd_idx  = ARADDR[IDX_W+1:2];

  // ---------------------------------------------------------------------------
  // Write channel: holding latches and response
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what lets a same-edge read see the old register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= AWADDR;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= WDATA;
        end
        if (BVALID && BREADY) begin
          BVALID <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // NOTE: the register file is cleared by reset because software relies on
  // known power-up values; it is a bank of flops, not a RAM, so this is free
  // of the usual memory-reset restrictions.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && wr_ok) begin
      regs[wr_idx] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ar_fire) begin
      RVALID <= 1'b1;
      if (in_range(ARADDR)) begin
        RDATA <= regs[rd_idx];
        RRESP <= RESP_OKAY;
      end else begin
        RDATA <= '0;
        RRESP <= RESP_SLVERR;
      end
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//
// Scoreboard bench for axi_lite_reg_slave (default parameters). Stimulus tasks
// push expected B and R responses, computed from a plain array model of the
// register map, into queues; an independent monitor pops and compares them
// whenever the DUT presents BVALID or RVALID. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int NR     = 8;
  localparam int IW     = $clog2(NR);
  localparam int BUDGET = 200;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [AW-1:0] AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic [NR*DW-1:0] reg_q;

  always #5 ACLK = ~ACLK;

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } r_exp_t;

  logic [1:0]    b_q [$];
  r_exp_t        r_q [$];
  logic [DW-1:0] model [NR];
  int            total = 0;
  int            bad   = 0;
  bit            rand_ready = 1'b0;
  bit            b_open = 1'b0;
  bit            r_open = 1'b0;
  logic [1:0]    b_exp;
  r_exp_t        r_exp;

  task automatic check(input string name, input logic [NR*DW-1:0] act,
                       input logic [NR*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return a < NR * 4;
  endfunction

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endfunction

  // Issue one write; AW and W start after their own delays (in cycles).
  // Called and returns 1 ns after a rising edge. The commit edge is the later
  // of the two handshakes, so the model updates just after that edge.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int aw_dly, input int w_dly);
    bit aw_ok = 1'b0;
    bit w_ok  = 1'b0;
    fork
      begin
        if (aw_dly > 0) begin repeat (aw_dly) @(posedge ACLK); #1; end
        AWADDR  = a;
        AWVALID = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
          @(negedge ACLK);
          if (AWREADY) begin aw_ok = 1'b1; break; end
        end
        check("aw_handshake", aw_ok, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
      end
      begin
        if (w_dly > 0) begin repeat (w_dly) @(posedge ACLK); #1; end
        WDATA  = d;
        WVALID = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
          @(negedge ACLK);
          if (WREADY) begin w_ok = 1'b1; break; end
        end
        check("w_handshake", w_ok, 1);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
      end
    join
    if (aw_ok && w_ok) begin
      if (addr_ok(a)) model[a[IW+1:2]] = d;
      b_q.push_back(addr_ok(a) ? 2'b00 : 2'b10);
    end
  endtask

  // Issue one read. The expectation is taken on the falling edge before the
  // handshake edge, i.e. before any write committing on that edge.
  task automatic do_read(input logic [AW-1:0] a);
    bit ok = 1'b0;
    r_exp_t e;
    ARADDR  = a;
    ARVALID = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge ACLK);
      if (ARREADY) begin ok = 1'b1; break; end
    end
    check("ar_handshake", ok, 1);
    if (ok) begin
      e.data = addr_ok(a) ? model[a[IW+1:2]] : '0;
      e.resp = addr_ok(a) ? 2'b00 : 2'b10;
      r_q.push_back(e);
    end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge ACLK);
      if (b_q.size() == 0 && r_q.size() == 0 && !BVALID && !RVALID) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1);
    @(posedge ACLK); #1;
  endtask

  // Monitor: compares every presented response against the scoreboard and
  // checks it stays stable until accepted.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (BVALID) begin
        if (!b_open) begin
          if (b_q.size() == 0) check("b_unexpected", BVALID, 0);
          else begin b_exp = b_q.pop_front(); b_open = 1'b1; end
        end
        if (b_open) begin
          check("bresp", BRESP, b_exp);
          check("awready_during_b", AWREADY, 0);
          check("wready_during_b", WREADY, 0);
        end
        if (BREADY) b_open = 1'b0;
      end
      if (RVALID) begin
        if (!r_open) begin
          if (r_q.size() == 0) check("r_unexpected", RVALID, 0);
          else begin r_exp = r_q.pop_front(); r_open = 1'b1; end
        end
        if (r_open) begin
          check("rdata", RDATA, r_exp.data);
          check("rresp", RRESP, r_exp.resp);
          check("arready_during_r", ARREADY, 0);
        end
        if (RREADY) r_open = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge ACLK); #1;
      if (rand_ready) begin
        BREADY = ($urandom_range(0, 3) != 0);
        RREADY = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] ra;
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    model_clear();

    // Reset state
    #3;
    check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("rst_valids", {BVALID, RVALID}, 2'b00);
    check("rst_reg_q", reg_q, '0);
    check("rst_rdata", {RDATA, RRESP, BRESP}, '0);
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    check("ready_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(posedge ACLK); #1;
    check("ready_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

    // AW and W together, then read back
    do_write(32'h04, 32'hDEADBEEF, 0, 0);
    check("bvalid_commit_edge", BVALID, 1);
    check("reg1_written", reg_q[1*DW +: DW], 32'hDEADBEEF);
    do_read(32'h04);
    wait_idle();

    // W leads AW by several cycles
    fork
      do_write(32'h08, 32'h12345678, 4, 0);
      begin
        @(posedge ACLK); #1;
        check("wready_low_after_w", WREADY, 0);
        check("no_early_bvalid", BVALID, 0);
        @(posedge ACLK); #1;
        check("wready_still_low", WREADY, 0);
      end
    join
    check("reg2_written", reg_q[2*DW +: DW], 32'h12345678);
    wait_idle();

    // Out-of-range write and read
    do_write(32'h40, 32'hFFFFFFFF, 0, 0);
    check("oob_no_change", reg_q, model_vec());
    check("oob_reg1_kept", reg_q[1*DW +: DW], 32'hDEADBEEF);
    do_read(32'h40);
    wait_idle();

    // Response back-pressure
    BREADY = 1'b0;
    do_write(32'h10, 32'hCAFE0001, 0, 0);
    fork
      do_write(32'h14, 32'hCAFE0002, 0, 0);
      begin
        repeat (5) begin
          @(negedge ACLK);
          check("bvalid_held", BVALID, 1);
          check("reg5_untouched", reg_q[5*DW +: DW], 32'h0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
      end
    join
    check("reg4_written", reg_q[4*DW +: DW], 32'hCAFE0001);
    check("reg5_written", reg_q[5*DW +: DW], 32'hCAFE0002);
    wait_idle();

    // Read on the same edge as a commit to the same register
    do_write(32'h0C, 32'hA5A5A5A5, 0, 0);
    wait_idle();
    fork
      do_write(32'h0C, 32'h5A5A5A5A, 0, 0);
      do_read(32'h0C);
    join
    check("same_edge_old_value", RDATA, 32'hA5A5A5A5);
    do_read(32'h0C);
    check("next_read_new_value", RDATA, 32'h5A5A5A5A);
    wait_idle();

    // Randomized concurrent traffic
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h20) : {27'd0, 5'($urandom)};
      ra = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h20) : {27'd0, 5'($urandom)};
      fork
        do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        begin
          if ($urandom_range(0, 1) == 1) do_read(ra);
        end
      join
      check("rand_reg_q", reg_q, model_vec());
    end
    rand_ready = 1'b0;
    BREADY = 1'b1;
    RREADY = 1'b1;
    wait_idle();

    // Reset mid-transaction: AW held without W, read response pending
    RREADY  = 1'b0;
    AWADDR  = 32'h08;
    AWVALID = 1'b1;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
        @(negedge ACLK);
        if (AWREADY) begin ok = 1'b1; break; end
      end
      check("lone_aw_handshake", ok, 1);
    end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("awready_while_held", AWREADY, 0);
    check("wready_independent", WREADY, 1);
    do_read(32'h08);
    @(posedge ACLK); #1;
    check("rvalid_pending", RVALID, 1);
    #2 ARESETN = 1'b0;
    b_q.delete();
    r_q.delete();
    b_open = 1'b0;
    r_open = 1'b0;
    model_clear();
    #1;
    check("mid_rst_valids", {BVALID, RVALID}, 2'b00);
    check("mid_rst_reg_q", reg_q, model_vec());
    check("mid_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    WDATA  = 32'hFFFFFFFF;
    WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    repeat (4) begin
      @(negedge ACLK);
      check("no_commit_after_rst", BVALID, 0);
      check("reg_q_zero_after_rst", reg_q, model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
